// File: rtl/rom_burst_arbiter.sv
// Two-requester round-robin burst arbiter in front of a synchronous ROM.
// A 2-stage tag pipeline routes each returned ROM word to the owner of the beat.
module rom_burst_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [1:0]    req0_len,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [1:0]    req1_len,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_last,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_last,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          t1_valid_q, t1_valid_d;
  logic          t1_owner_q, t1_owner_d;
  logic          t1_last_q, t1_last_d;

  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp0_last_q, rsp0_last_d;
  logic [DW-1:0] rsp0_data_q, rsp0_data_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic          rsp1_last_q, rsp1_last_d;
  logic [DW-1:0] rsp1_data_q, rsp1_data_d;

  logic          grant0, grant1;
  logic          beat, beat_owner, beat_last;
  logic [1:0]    len_sel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    beat       = 1'b0;
    beat_owner = owner_q;
    beat_last  = 1'b0;
    len_sel    = '0;

    case (state_q)
      IDLE: begin
        // rr_q=1 means requester 1 wins a tie; grants are blocked while rst is held
        if (!rst) begin
          grant1 = req1_valid & (~req0_valid | rr_q);
          grant0 = req0_valid & ~grant1;
        end
        if (grant0 || grant1) begin
          beat       = 1'b1;
          beat_owner = grant1;
          addr_d     = grant1 ? req1_addr : req0_addr;
          len_sel    = grant1 ? req1_len : req0_len;
          beat_last  = (len_sel == 2'd0);
          rr_d       = grant0;
          owner_d    = grant1;
          if (len_sel != 2'd0) begin
            state_d = BURST;
            cnt_d   = len_sel;
          end
        end
      end
      BURST: begin
        beat      = 1'b1;
        addr_d    = addr_q + AW'(1);
        beat_last = (cnt_q == 2'd1);
        cnt_d     = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    t1_valid_d = beat;
    t1_owner_d = beat_owner;
    t1_last_d  = beat_last;

    rsp0_valid_d = t1_valid_q & ~t1_owner_q;
    rsp0_last_d  = rsp0_valid_d & t1_last_q;
    rsp0_data_d  = rsp0_valid_d ? rom_data : rsp0_data_q;
    rsp1_valid_d = t1_valid_q & t1_owner_q;
    rsp1_last_d  = rsp1_valid_d & t1_last_q;
    rsp1_data_d  = rsp1_valid_d ? rom_data : rsp1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      addr_q       <= '0;
      t1_valid_q   <= 1'b0;
      t1_owner_q   <= 1'b0;
      t1_last_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_last_q  <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_last_q  <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      addr_q       <= addr_d;
      t1_valid_q   <= t1_valid_d;
      t1_owner_q   <= t1_owner_d;
      t1_last_q    <= t1_last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_last_q  <= rsp0_last_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_last_q  <= rsp1_last_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  // addr_d equals addr_q whenever no beat issues, so the ROM address holds
  assign rom_en     = beat;
  assign rom_addr   = addr_d;
  assign busy       = (state_q == BURST);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_last  = rsp0_last_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_last  = rsp1_last_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: directed vector tables plus randomized traffic,
// all checked against a beat-queue model of the arbiter and a registered ROM model.
module tb_rom_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_addr, req1_addr;
  logic [1:0]  req0_len, req1_len;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_last, rsp1_valid, rsp1_last;
  logic [19:0] rsp0_data, rsp1_data;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data = '0;
  logic        busy;

  rom_burst_arbiter #(.AW(6), .DW(20)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [19:0] rom_img [64];

  always @(posedge clk) if (rom_en) rom_data <= rom_img[rom_addr];

  typedef struct {
    logic       rst, v0;  logic [5:0] a0; logic [1:0] l0;
    logic       v1;       logic [5:0] a1; logic [1:0] l1;
    logic       rdy0, rdy1, en; logic [5:0] addr; logic bz;
    logic       rv0, rv1; logic [19:0] rd; logic rl;
  } vec_t;

  typedef struct { logic owner; logic [5:0] addr; logic last; } beat_t;

  int    n_vec = 0;
  int    n_bad = 0;
  vec_t  tab[$];

  // model state
  beat_t       beatq[$];
  logic        fav1;
  logic [5:0]  last_addr;
  logic        sv[4], so[4], sl[4];
  logic [19:0] sd[4];
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v0, input logic [5:0] a0, input logic [1:0] l0,
                              input logic v1, input logic [5:0] a1, input logic [1:0] l1,
                              input logic rdy0, input logic rdy1, input logic en, input logic [5:0] ad,
                              input logic bz, input logic rv0, input logic rv1, input logic [19:0] rd,
                              input logic rl);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.l0 = l0; v.v1 = v1; v.a1 = a1; v.l1 = l1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.en = en; v.addr = ad; v.bz = bz;
    v.rv0 = rv0; v.rv1 = rv1; v.rd = rd; v.rl = rl;
    return v;
  endfunction

  task automatic model_reset();
    beatq.delete();
    fav1 = 1'b0;
    last_addr = '0;
    for (int i = 0; i < 4; i++) begin sv[i] = 0; so[i] = 0; sl[i] = 0; sd[i] = '0; end
  endtask

  task automatic step(input vec_t v, input bit use_tab);
    logic e_r0, e_r1, e_en, e_bz, ev0, ev1, el;
    logic [5:0]  e_ad;
    logic [19:0] ed;
    int win, s, s2;
    beat_t b;
    rst = v.rst;
    req0_valid = v.v0; req0_addr = v.a0; req0_len = v.l0;
    req1_valid = v.v1; req1_addr = v.a1; req1_len = v.l1;
    #1;
    if (v.rst) model_reset();
    s = cyc % 4; s2 = (cyc + 2) % 4;
    ev0 = sv[s] && !so[s]; ev1 = sv[s] && so[s]; el = sl[s]; ed = sd[s];
    sv[s] = 0;
    e_r0 = 0; e_r1 = 0; e_en = 0;
    e_bz = (beatq.size() != 0);
    if (!v.rst && beatq.size() == 0) begin
      win = -1;
      if (v.v0 && v.v1) win = fav1 ? 1 : 0;
      else if (v.v0) win = 0;
      else if (v.v1) win = 1;
      if (win >= 0) begin
        logic [5:0] base;
        logic [1:0] ln;
        base = (win == 1) ? v.a1 : v.a0;
        ln   = (win == 1) ? v.l1 : v.l0;
        if (win == 1) e_r1 = 1; else e_r0 = 1;
        fav1 = (win == 0);
        for (int k = 0; k <= int'(ln); k++) begin
          b.owner = (win == 1);
          b.addr  = 6'((int'(base) + k) % 64);
          b.last  = (k == int'(ln));
          beatq.push_back(b);
        end
      end
    end
    if (beatq.size() != 0) begin
      b = beatq.pop_front();
      e_en = 1; last_addr = b.addr;
      sv[s2] = 1; so[s2] = b.owner; sl[s2] = b.last; sd[s2] = rom_img[b.addr];
    end
    e_ad = last_addr;

    chk("req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("rom_en", 32'(rom_en), 32'(e_en));
    chk("rom_addr", 32'(rom_addr), 32'(e_ad));
    chk("busy", 32'(busy), 32'(e_bz));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    chk("rsp0_last", 32'(rsp0_last), 32'(ev0 & el));
    chk("rsp1_last", 32'(rsp1_last), 32'(ev1 & el));
    if (ev0) chk("rsp0_data", 32'(rsp0_data), 32'(ed));
    if (ev1) chk("rsp1_data", 32'(rsp1_data), 32'(ed));
    if (v.rst) begin
      chk("rst_rsp0_data", 32'(rsp0_data), 32'h0);
      chk("rst_rsp1_data", 32'(rsp1_data), 32'h0);
    end

    if (use_tab) begin
      chk("tab_ready0", 32'(req0_ready), 32'(v.rdy0));
      chk("tab_ready1", 32'(req1_ready), 32'(v.rdy1));
      chk("tab_rom_en", 32'(rom_en), 32'(v.en));
      chk("tab_rom_addr", 32'(rom_addr), 32'(v.addr));
      chk("tab_busy", 32'(busy), 32'(v.bz));
      chk("tab_rsp0_valid", 32'(rsp0_valid), 32'(v.rv0));
      chk("tab_rsp1_valid", 32'(rsp1_valid), 32'(v.rv1));
      if (v.rv0) begin
        chk("tab_rsp0_data", 32'(rsp0_data), 32'(v.rd));
        chk("tab_rsp0_last", 32'(rsp0_last), 32'(v.rl));
      end
      if (v.rv1) begin
        chk("tab_rsp1_data", 32'(rsp1_data), 32'(v.rd));
        chk("tab_rsp1_last", 32'(rsp1_last), 32'(v.rl));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 64; i++) rom_img[i] = 20'((i * 20'h00513) ^ 20'hA5C3);
    rom_img[6'h00] = 20'h0200A; rom_img[6'h01] = 20'h00300; rom_img[6'h02] = 20'h08101;
    rom_img[6'h3E] = 20'h08201; rom_img[6'h3F] = 20'h0400D;
    model_reset();

    // reset state
    repeat (2) tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,6'h00,0, 0,0,0,0));
    // single beat, then 4-beat wrap burst from req1 (addr change after accept ignored)
    tab.push_back(mk(0,1,6'h00,0, 0,0,0,       1,0,1,6'h00,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h00,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     1,6'h3E,3,   0,1,1,6'h3E,0, 1,0,20'h0200A,1));
    tab.push_back(mk(0,0,0,0,     1,6'h10,1,   0,0,1,6'h3F,1, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     1,6'h10,1,   0,0,1,6'h00,1, 0,1,20'h08201,0));
    tab.push_back(mk(0,0,0,0,     1,6'h10,1,   0,0,1,6'h01,1, 0,1,20'h0400D,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h01,0, 0,1,20'h0200A,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h01,0, 0,1,20'h00300,1));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h01,0, 0,0,0,0));
    // req1 waits behind a 3-beat req0 burst and follows with no gap
    tab.push_back(mk(0,1,6'h02,2, 1,6'h3F,0,   1,0,1,6'h02,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     1,6'h3F,0,   0,0,1,6'h03,1, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     1,6'h3F,0,   0,0,1,6'h04,1, 1,0,rom_img[2],0));
    tab.push_back(mk(0,0,0,0,     1,6'h3F,0,   0,1,1,6'h3F,0, 1,0,rom_img[3],0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3F,0, 1,0,rom_img[4],1));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3F,0, 0,1,20'h0400D,1));
    // alternating grants from reset
    repeat (2) tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,6'h00,0, 0,0,0,0));
    tab.push_back(mk(0,1,6'h01,0, 1,6'h3E,0,   1,0,1,6'h01,0, 0,0,0,0));
    tab.push_back(mk(0,1,6'h01,0, 1,6'h3E,0,   0,1,1,6'h3E,0, 0,0,0,0));
    tab.push_back(mk(0,1,6'h01,0, 1,6'h3E,0,   1,0,1,6'h01,0, 1,0,20'h00300,1));
    tab.push_back(mk(0,1,6'h01,0, 1,6'h3E,0,   0,1,1,6'h3E,0, 0,1,20'h08201,1));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3E,0, 1,0,20'h00300,1));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3E,0, 0,1,20'h08201,1));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3E,0, 0,0,0,0));
    // reset during beat 1 of a 4-beat burst
    tab.push_back(mk(0,1,6'h10,3, 0,0,0,       1,0,1,6'h10,0, 0,0,0,0));
    tab.push_back(mk(1,0,0,0,     0,0,0,       0,0,0,6'h00,0, 0,0,0,0));
    tab.push_back(mk(1,0,0,0,     0,0,0,       0,0,0,6'h00,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h00,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h00,0, 0,0,0,0));
    tab.push_back(mk(0,1,6'h3E,0, 0,0,0,       1,0,1,6'h3E,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3E,0, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3E,0, 1,0,20'h08201,1));
    tab.push_back(mk(0,0,0,0,     0,0,0,       0,0,0,6'h3E,0, 0,0,0,0));

    foreach (tab[i]) step(tab[i], 1'b1);

    for (int i = 0; i < 600; i++) begin
      rv = mk(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0);
      rv.rst = ($urandom_range(0, 49) == 0);
      rv.v0  = ($urandom_range(0, 2) != 0);
      rv.v1  = ($urandom_range(0, 2) != 0);
      rv.a0  = 6'($urandom_range(0, 63));
      rv.a1  = 6'($urandom_range(0, 63));
      rv.l0  = 2'($urandom_range(0, 3));
      rv.l1  = 2'($urandom_range(0, 3));
      step(rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameter AW, default 6, ROM address width.
REQ-002 Parameter DW, default 20, ROM data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req0_valid / req1_valid  input  1  requester N has a burst pending.
REQ-006 req0_addr / req1_addr  input  AW  burst start address.
REQ-007 req0_len / req1_len  input  2  burst length minus one (1..4 beats).
REQ-008 req0_ready / req1_ready  output  1  burst accepted this cycle (combinational).
REQ-009 rsp0_valid / rsp1_valid  output  1  registered; one beat of read data for requester N.
REQ-010 rsp0_data / rsp1_data  output  DW  registered read data.
REQ-011 rsp0_last / rsp1_last  output  1  registered; final beat of burst.
REQ-012 rom_en  output  1  ROM address-register enable.
REQ-013 rom_addr  output  AW  ROM address; the ROM registers it on the rising edge when rom_en=1.
REQ-014 rom_data  input  DW  ROM output; valid in the cycle after rom_en/rom_addr are sampled.
REQ-015 busy  output  1  high while in BURST state.

Function
REQ-016 States SHALL be IDLE and BURST only.
REQ-017 In IDLE, reqN_ready SHALL be asserted only if reqN_valid=1 and N wins arbitration; at most one ready is high per cycle.
REQ-018 Arbitration SHALL be round-robin: a sole valid requester wins; when both are valid, the requester not granted most recently wins.
REQ-019 The accept cycle SHALL issue beat 0: rom_en=1, rom_addr=reqN_addr.
REQ-020 If reqN_len=0, the arbiter SHALL remain in IDLE; otherwise it SHALL go to BURST with remaining-beat count = reqN_len and the owner recorded.
REQ-021 In BURST, the arbiter SHALL issue one beat per cycle: rom_en=1, rom_addr = previous address + 1, modulo 2^AW (63 wraps to 0).
REQ-022 In BURST, both readies SHALL be 0.
REQ-023 The arbiter SHALL return to IDLE in the cycle after its final beat is issued; the next accept is allowed in that cycle.
REQ-024 Back-to-back single-beat requests SHALL sustain one accept per cycle.
REQ-025 rom_en SHALL be 0 in every cycle with no beat issued, and rom_addr SHALL hold its value.
REQ-026 A beat issued in cycle T SHALL produce rspN_valid=1 in cycle T+2, with rspN_data = rom_data captured at the end of T+1.
REQ-027 rspN_last SHALL be high only with the final beat of the burst.
REQ-028 Responses SHALL be routed only to the owner of the beat, via a 2-stage tag pipeline (valid, owner, last).
REQ-029 A response has no backpressure; requesters SHALL accept every rsp pulse.
REQ-030 reqN_addr and reqN_len SHALL be sampled only in the accept cycle; changes after acceptance have no effect.
REQ-031 A requester deasserting valid before acceptance SHALL lose nothing; no state changes.
REQ-032 The round-robin pointer SHALL update only on accept.

Reset
REQ-033 While rst=1: state=IDLE, beat count=0, pointer favouring req0 next, rom_en=0, rom_addr=0, all rsp*_valid/last=0, rsp*_data=0, busy=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst immediately; no response pulse for in-flight beats SHALL appear after reset.
REQ-035 The first accept after reset release SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-036 ROM holds the 64x20 image (0x00=0x0200A, 0x01=0x00300, 0x02=0x08101, 0x3E=0x08201, 0x3F=0x0400D): req0 addr=0x00 len=0 accepted at T -> rsp0_valid=1, rsp0_last=1, rsp0_data=0x0200A at T+2, single pulse.
REQ-037 req1 addr=0x3E len=3 -> rom_addr 0x3E,0x3F,0x00,0x01 on T..T+3; rsp1_data 0x08201,0x0400D,0x0200A,0x00300 on T+2..T+5; rsp1_last only at T+5; busy high T+1..T+3.
REQ-038 Both valid every cycle, len=0, from reset -> grants alternate 0,1,0,1; one rsp per cycle from T+2 with matching owner.
REQ-039 req0 burst len=2 in progress, req1 valid throughout -> req1_ready=0 while busy; req1 accepted in the cycle busy falls; req1 beat 0 follows req0 last beat with no gap.
REQ-040 rst asserted during beat 1 of a len=3 burst -> all outputs zero immediately; no rsp pulses after release; next req0 accepted normally.
